// File: rtl/dro_mon_pkg.sv
// Shared types and constants for the DRO pulse monitor.
// Holds the state encoding, the error-code map and the related widths.
// No logic lives here.
package dro_mon_pkg;

  localparam int STATE_W = 2;
  localparam int CODE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_STORED  = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  localparam logic [CODE_W-1:0] ERR_NONE       = 3'd0;
  localparam logic [CODE_W-1:0] ERR_SPURIOUS   = 3'd1;
  localparam logic [CODE_W-1:0] ERR_SETUP      = 3'd2;
  localparam logic [CODE_W-1:0] ERR_DOUBLE_SET = 3'd3;
  localparam logic [CODE_W-1:0] ERR_EARLY      = 3'd4;
  localparam logic [CODE_W-1:0] ERR_MISSING    = 3'd5;
  localparam logic [CODE_W-1:0] ERR_BUSY       = 3'd6;
  // Simultaneous set/reset shares the busy code.
  localparam logic [CODE_W-1:0] ERR_SIMUL      = 3'd6;
  localparam logic [CODE_W-1:0] ERR_HOLD       = 3'd7;

endpackage

// File: rtl/dro_mon_err_cnt.sv
// Error reporting: priority-encodes the per-cycle violation flags into one code.
// Latency: strobe, code and saturating count are registered, one cycle after the flags.
// No backpressure: every flagged cycle produces a strobe.
module dro_mon_err_cnt
  import dro_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_simul,
  input  logic              i_busy,
  input  logic              i_early,
  input  logic              i_spurious,
  input  logic              i_setup,
  input  logic              i_hold,
  input  logic              i_double_set,
  input  logic              i_missing,
  output logic              o_err_valid,
  output logic [CODE_W-1:0] o_err_code,
  output logic [CNT_W-1:0]  o_err_cnt
);

  logic [CODE_W-1:0] w_code;
  logic              r_err_valid;
  logic [CODE_W-1:0] r_err_code;
  logic [CNT_W-1:0]  r_err_cnt;

  // Pick the single highest-priority violation of this cycle.
  always_comb begin
    w_code = ERR_NONE;
    if (i_simul)           w_code = ERR_SIMUL;
    else if (i_busy)       w_code = ERR_BUSY;
    else if (i_early)      w_code = ERR_EARLY;
    else if (i_spurious)   w_code = ERR_SPURIOUS;
    else if (i_setup)      w_code = ERR_SETUP;
    else if (i_hold)       w_code = ERR_HOLD;
    else if (i_double_set) w_code = ERR_DOUBLE_SET;
    else if (i_missing)    w_code = ERR_MISSING;
  end

  // Register the strobe/code and bump the count on the same edge, holding at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_cnt   <= '0;
    end else begin
      r_err_valid <= (w_code != ERR_NONE);
      r_err_code  <= w_code;
      if ((w_code != ERR_NONE) && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_err_valid = r_err_valid;
  assign o_err_code  = r_err_code;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: rtl/dro_pulse_monitor.sv
// Reference model and protocol/timing checker for a DRO cell's set/reset/out pulses.
// Latency: all outputs registered; errors appear one cycle after the offending sample.
// No backpressure; optional hold check built when DRO_MON_HOLD_CHECK_EN is defined.
module dro_pulse_monitor
  import dro_mon_pkg::*;
#(
  parameter int DLY_MIN   = 2,
  parameter int DLY_MAX   = 8,
  parameter int SETUP_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_i,
  input  logic               reset_i,
  input  logic               out_i,
  output logic [STATE_W-1:0] state_o,
  output logic               err_valid_o,
  output logic [CODE_W-1:0]  err_code_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic [CNT_W-1:0]   pulse_cnt_o
);

  localparam int AGE_W  = $clog2(SETUP_CYC + 1);
  localparam int WAIT_W = $clog2(DLY_MAX + 1);
  localparam logic [AGE_W-1:0]  SETUP_L   = AGE_W'(SETUP_CYC);
  localparam logic [WAIT_W-1:0] DLY_MIN_L = WAIT_W'(DLY_MIN);
  localparam logic [WAIT_W-1:0] DLY_MAX_L = WAIT_W'(DLY_MAX);

  state_t            r_state;
  logic [AGE_W-1:0]  r_age;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_pulse_cnt;

  logic w_idle, w_stored, w_readout, w_set_acc;
  logic w_simul, w_busy, w_early, w_spurious, w_setup, w_double_set, w_missing, w_hold;

  assign w_idle       = (r_state == S_IDLE);
  assign w_stored     = (r_state == S_STORED);
  assign w_readout    = (r_state == S_READOUT);
  // A set outside READOUT is always taken, even alongside a reset.
  assign w_set_acc    = set_i & ~w_readout;

  assign w_simul      = set_i & reset_i & ~w_readout;
  assign w_busy       = w_readout & (set_i | reset_i);
  assign w_early      = w_readout & out_i & (r_wait < DLY_MIN_L);
  assign w_spurious   = out_i & ~w_readout;
  assign w_setup      = w_stored & reset_i & ~set_i & (r_age < SETUP_L);
  assign w_double_set = w_stored & set_i;
  assign w_missing    = w_readout & ~out_i & (r_wait >= DLY_MAX_L);

`ifdef DRO_MON_HOLD_CHECK_EN
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_L = HOLD_W'(HOLD_CYC);
  logic [HOLD_W-1:0] r_hold;

  assign w_hold = w_set_acc & (r_hold < HOLD_L);

  // Cycles since the last reset pulse; starts saturated so no reset is pending after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= HOLD_L;
    end else if (reset_i) begin
      r_hold <= HOLD_W'(1);
    end else if (r_hold != HOLD_L) begin
      r_hold <= r_hold + 1'b1;
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  // Stored-state model with its setup (age) and readout-window (wait) timers.
  // Both timers count cycles elapsed since their event sample, so the event edge loads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_age       <= '0;
      r_wait      <= '0;
      r_pulse_cnt <= '0;
    end else begin
      if (r_age != SETUP_L) begin
        r_age <= r_age + 1'b1;
      end
      case (r_state)
        S_IDLE, S_STORED: begin
          if (set_i) begin
            r_state <= S_STORED;
            r_age   <= AGE_W'(1);
          end else if (reset_i && w_stored) begin
            r_state <= S_READOUT;
            r_wait  <= WAIT_W'(1);
          end
        end
        S_READOUT: begin
          if (out_i) begin
            r_state <= S_IDLE;
            if (!w_early) begin
              r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end
          end else if (r_wait >= DLY_MAX_L) begin
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  dro_mon_err_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_simul      (w_simul),
    .i_busy       (w_busy),
    .i_early      (w_early),
    .i_spurious   (w_spurious),
    .i_setup      (w_setup),
    .i_hold       (w_hold),
    .i_double_set (w_double_set),
    .i_missing    (w_missing),
    .o_err_valid  (err_valid_o),
    .o_err_code   (err_code_o),
    .o_err_cnt    (err_cnt_o)
  );

  assign state_o     = r_state;
  assign pulse_cnt_o = r_pulse_cnt;

endmodule

// File: tb/tb_dro_pulse_monitor.sv
// Directed bench for dro_pulse_monitor with a queue-based error scoreboard.
// Stimulus pushes expected (cycle, code) pairs; a monitor pops them on err_valid_o.
// State and pulse counts are checked inline against hand-computed constants.
module tb_dro_pulse_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_i;
  logic       reset_i;
  logic       out_i;
  logic [1:0] state_o;
  logic       err_valid_o;
  logic [2:0] err_code_o;
  logic [7:0] err_cnt_o;
  logic [7:0] pulse_cnt_o;

  typedef struct {
    int cyc;
    int code;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   model_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dro_pulse_monitor #(
    .DLY_MIN   (2),
    .DLY_MAX   (8),
    .SETUP_CYC (3),
    .HOLD_CYC  (2),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .set_i       (set_i),
    .reset_i     (reset_i),
    .out_i       (out_i),
    .state_o     (state_o),
    .err_valid_o (err_valid_o),
    .err_code_o  (err_code_o),
    .err_cnt_o   (err_cnt_o),
    .pulse_cnt_o (pulse_cnt_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one sample: applied at the falling edge, taken by the next rising edge.
  task automatic drive(input logic s, input logic r, input logic o);
    @(negedge clk);
    set_i   = s;
    reset_i = r;
    out_i   = o;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Expect an error caused by the sample just driven, reported off cycles later.
  task automatic expect_err(input int off, input int code);
    exp_t e;
    e.cyc  = cyc + 1 + off;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    idle(3);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst     = 1'b1;
    set_i   = 1'b0;
    reset_i = 1'b0;
    out_i   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    model_cnt = 0;
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation in code and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (err_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_err_valid", int'(err_valid_o), 0);
      end else begin
        e = exp_q.pop_front();
        check("err_code", int'(err_code_o), e.code);
        check("err_cycle", cyc, e.cyc);
        model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
        check("err_cnt", int'(err_cnt_o), model_cnt);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("missing_err_valid", int'(err_valid_o), 1);
    end
  end

  initial begin
    rst     = 1'b1;
    set_i   = 1'b0;
    reset_i = 1'b0;
    out_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", int'(state_o), 0);
    check("rst_err_valid", int'(err_valid_o), 0);
    check("rst_err_code", int'(err_code_o), 0);
    check("rst_err_cnt", int'(err_cnt_o), 0);
    check("rst_pulse_cnt", int'(pulse_cnt_o), 0);
    rst = 1'b0;

    // Legal readout: set, reset 4 cycles later, out 3 cycles after reset.
    drive(1, 0, 0); idle(3); drive(0, 1, 0);
    idle(1); check("legal_state_readout", int'(state_o), 2);
    idle(1); drive(0, 0, 1);
    idle(1); check("legal_state_idle", int'(state_o), 0);
    check("legal_pulse_cnt", int'(pulse_cnt_o), 1);
    drain(); do_rst();

    // Setup violation: reset one cycle after set, then out at reset+2 still counts.
    drive(1, 0, 0); drive(0, 1, 0); expect_err(0, 2);
    idle(1); drive(0, 0, 1);
    idle(1); check("setup_state", int'(state_o), 0);
    check("setup_pulse_cnt", int'(pulse_cnt_o), 1);
    drain(); do_rst();

    // Early out at reset+1.
    drive(1, 0, 0); idle(3); drive(0, 1, 0);
    drive(0, 0, 1); expect_err(0, 4);
    idle(1); check("early_state", int'(state_o), 0);
    check("early_pulse_cnt", int'(pulse_cnt_o), 0);
    drain(); do_rst();

    // Missing out: no out after reset, one code 5 reported for the reset+8 sample.
    drive(1, 0, 0); idle(3); drive(0, 1, 0); expect_err(8, 5);
    idle(8);
    idle(1); check("missing_state", int'(state_o), 0);
    check("missing_pulse_cnt", int'(pulse_cnt_o), 0);
    drain(); do_rst();

    // Out exactly at reset+8 is the last legal slot.
    drive(1, 0, 0); idle(3); drive(0, 1, 0);
    idle(7); drive(0, 0, 1);
    idle(1); check("late_edge_state", int'(state_o), 0);
    check("late_edge_pulse_cnt", int'(pulse_cnt_o), 1);
    drain(); do_rst();

    // Spurious out while IDLE.
    drive(0, 0, 1); expect_err(0, 1);
    idle(1); check("spurious_state", int'(state_o), 0);
    drain(); do_rst();

    // Double set while STORED.
    drive(1, 0, 0); drive(1, 0, 0); expect_err(0, 3);
    idle(1); check("double_set_state", int'(state_o), 1);
    drain(); do_rst();

    // Simultaneous set and reset from IDLE acts as a set.
    drive(1, 1, 0); expect_err(0, 6);
    idle(1); check("simul_state", int'(state_o), 1);
    drain(); do_rst();

    // Set during READOUT is busy and ignored; the out still completes the readout.
    drive(1, 0, 0); idle(3); drive(0, 1, 0);
    drive(1, 0, 0); expect_err(0, 6);
    drive(0, 0, 1);
    idle(1); check("busy_state", int'(state_o), 0);
    check("busy_pulse_cnt", int'(pulse_cnt_o), 1);
    drain(); do_rst();

    // rst in the middle of READOUT clears everything and discards the pending out.
    drive(0, 0, 1); expect_err(0, 1);
    drive(1, 0, 0); idle(3); drive(0, 1, 0); idle(2); drive(0, 0, 1);
    drive(1, 0, 0); idle(3); drive(0, 1, 0); idle(2);
    check("pre_rst_pulse_cnt", int'(pulse_cnt_o), 1);
    check("pre_rst_state", int'(state_o), 2);
    @(negedge clk);
    rst     = 1'b1;
    set_i   = 1'b0;
    reset_i = 1'b0;
    out_i   = 1'b0;
    @(negedge clk);
    check("midrst_state", int'(state_o), 0);
    check("midrst_err_valid", int'(err_valid_o), 0);
    check("midrst_err_code", int'(err_code_o), 0);
    check("midrst_err_cnt", int'(err_cnt_o), 0);
    check("midrst_pulse_cnt", int'(pulse_cnt_o), 0);
    rst       = 1'b0;
    model_cnt = 0;
    idle(12);
    check("post_rst_state", int'(state_o), 0);
    drain(); do_rst();

    // Error counter saturation with 300 back-to-back spurious outs.
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 1); expect_err(0, 1);
    end
    idle(1);
    check("sat_err_cnt", int'(err_cnt_o), 255);
    drain(); do_rst();

    // Set one cycle after a reset pulse: hold error only when the check is built in.
    drive(0, 1, 0);
    drive(1, 0, 0);
`ifdef DRO_MON_HOLD_CHECK_EN
    expect_err(0, 7);
`endif
    idle(1); check("hold_state", int'(state_o), 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
